// File: rtl/instr_cache_controller.sv
// -----------------------------------------------------------------------------
// instr_cache_controller
//
// Miss/refill and flush sequencer for a direct-mapped instruction cache.
// The fetch address is compared against the cache's tag/valid read-out. On a
// miss the fetch stage is stalled, the line is read word-by-word from backing
// memory, written into the data array, and then tagged valid. All valid bits
// are cleared after reset and on a flush request.
//
// State table
//   state  | meaning
//   FLUSH  | sweep every set, writing valid = 0; stall held
//   IDLE   | lookup; hit passes through with no stall, miss starts a fill
//   FILL   | fetch line words from memory, write them into the data array
//   DONE   | one settle cycle so the next lookup sees the new tag/valid
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   pc_req, pc_addr   fetch request and byte address
//   flush             invalidate-all request (pulse or level)
//   c_valid, c_tag    tag/valid read-out for set(pc_addr), combinational
//   stall             fetch hold; instruction usable when pc_req & ~stall
//   mem_req, mem_addr backing-memory read request and word address
//   mem_ack, mem_rd   read completion strobe and data
//   d_we, d_addr,d_wd data-array write port
//   v_we, v_set,      tag/valid-array write port
//   v_val, v_tag
// -----------------------------------------------------------------------------
module instr_cache_controller #(
    parameter  int SET_W  = 12,
    parameter  int LINE_W = 2,
    localparam int TAG_W  = 30 - SET_W - LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_req,
    input  logic [31:0]       pc_addr,
    input  logic              flush,
    input  logic              c_valid,
    input  logic [TAG_W-1:0]  c_tag,
    output logic              stall,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rd,
    output logic              d_we,
    output logic [31:0]       d_addr,
    output logic [31:0]       d_wd,
    output logic              v_we,
    output logic [SET_W-1:0]  v_set,
    output logic              v_val,
    output logic [TAG_W-1:0]  v_tag
);

    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Line base is the word address with the in-line word offset dropped.
    localparam int LB_W = 30 - LINE_W;

    localparam logic [SET_W-1:0]  SET_LAST  = '1;
    localparam logic [LINE_W-1:0] WORD_LAST = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [SET_W-1:0]  flush_idx;
    logic [SET_W-1:0]  flush_idx_nxt;
    logic [LINE_W-1:0] word_cnt;
    logic [LINE_W-1:0] word_cnt_nxt;
    logic [LB_W-1:0]   line_base;
    logic [LB_W-1:0]   line_base_nxt;
    logic              flush_pend;
    logic              flush_pend_nxt;

    logic [TAG_W-1:0]  pc_tag;
    logic              hit;

    // Byte offset and in-line word index are not needed for the lookup; the
    // fill always restarts at word 0 of the line.
    logic              unused_bits;
    assign unused_bits = &{1'b0, pc_addr[LINE_W+1:0]};

    assign pc_tag = pc_addr[31 -: TAG_W];
    assign hit    = c_valid & (c_tag == pc_tag);

    // Address is held stable for the whole word because it is built only
    // from registered state.
    assign mem_addr = {line_base, word_cnt, 2'b00};
    assign d_addr   = mem_addr;
    assign d_wd     = mem_rd;

    always_comb begin
        state_nxt      = state;
        flush_idx_nxt  = flush_idx;
        word_cnt_nxt   = word_cnt;
        line_base_nxt  = line_base;
        flush_pend_nxt = flush_pend;

        stall   = 1'b1;
        mem_req = 1'b0;
        d_we    = 1'b0;
        v_we    = 1'b0;
        v_set   = flush_idx;
        v_val   = 1'b0;
        v_tag   = '0;

        case (state)
            ST_FLUSH: begin
                v_we  = 1'b1;
                v_set = flush_idx;
                if (flush_idx == SET_LAST) begin
                    state_nxt     = ST_IDLE;
                    flush_idx_nxt = '0;
                end else begin
                    flush_idx_nxt = flush_idx + SET_W'(1);
                end
            end

            ST_IDLE: begin
                if (flush || flush_pend) begin
                    // Flush wins over a pending miss; the fetch stays stalled
                    // and is re-looked-up after the sweep.
                    stall          = 1'b1;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = ST_FLUSH;
                end else if (pc_req && !hit) begin
                    stall         = 1'b1;
                    line_base_nxt = pc_addr[31:LINE_W+2];
                    word_cnt_nxt  = '0;
                    state_nxt     = ST_FILL;
                end else begin
                    stall = 1'b0;
                end
            end

            ST_FILL: begin
                mem_req = 1'b1;
                if (flush) begin
                    flush_pend_nxt = 1'b1;
                end
                if (mem_ack) begin
                    d_we         = 1'b1;
                    word_cnt_nxt = word_cnt + LINE_W'(1);
                    if (word_cnt == WORD_LAST) begin
                        // Tag/valid goes in with the last word so the line is
                        // never marked valid while partly written.
                        v_we      = 1'b1;
                        v_set     = line_base[SET_W-1:0];
                        v_tag     = line_base[LB_W-1 -: TAG_W];
                        v_val     = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (flush) begin
                    flush_pend_nxt = 1'b1;
                end
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_FLUSH;
            end
        endcase

        // While reset is held nothing may be written or requested.
        if (reset) begin
            stall   = 1'b1;
            mem_req = 1'b0;
            d_we    = 1'b0;
            v_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FLUSH;
            flush_idx  <= '0;
            word_cnt   <= '0;
            flush_pend <= 1'b0;
            line_base  <= '0;
        end else begin
            state      <= state_nxt;
            flush_idx  <= flush_idx_nxt;
            word_cnt   <= word_cnt_nxt;
            flush_pend <= flush_pend_nxt;
            line_base  <= line_base_nxt;
        end
    end

endmodule

// File: tb/tb_instr_cache_controller.sv
module tb_instr_cache_controller;

    localparam int SET_W  = 12;
    localparam int LINE_W = 2;
    localparam int TAG_W  = 30 - SET_W - LINE_W;
    localparam int SETS   = 1 << SET_W;
    localparam int WORDS  = 1 << LINE_W;
    localparam int LOGN   = 2048;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pc_req = 1'b0;
    logic [31:0]       pc_addr = '0;
    logic              flush = 1'b0;
    logic              c_valid;
    logic [TAG_W-1:0]  c_tag;
    logic              stall;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rd = '0;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wd;
    logic              v_we;
    logic [SET_W-1:0]  v_set;
    logic              v_val;
    logic [TAG_W-1:0]  v_tag;

    int checks = 0;
    int errors = 0;

    instr_cache_controller #(.SET_W(SET_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset), .pc_req(pc_req), .pc_addr(pc_addr),
        .flush(flush), .c_valid(c_valid), .c_tag(c_tag), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rd(mem_rd), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
        .v_we(v_we), .v_set(v_set), .v_val(v_val), .v_tag(v_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Cache arrays around the controller (written only by the monitor).
    logic              cache_valid [SETS];
    logic [TAG_W-1:0]  cache_tag   [SETS];
    logic [31:0]       cache_data  [SETS*WORDS];
    int                d_cnt  = 0;
    int                v1_cnt = 0;
    logic [31:0]       d_log_addr [LOGN];

    assign c_valid = cache_valid[pc_addr[SET_W+LINE_W+1:LINE_W+2]];
    assign c_tag   = cache_tag[pc_addr[SET_W+LINE_W+1:LINE_W+2]];

    // Backing memory: ack gap per word chosen by ack_mode.
    int ack_mode = 0;
    int gap      = 0;
    int wait_sum = 0;

    function automatic int pick_gap(input int mode);
        case (mode)
            1:       return 2;
            2:       return int'($urandom_range(0, 3));
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            if (gap == 0) begin
                mem_ack = 1'b1;
                mem_rd  = mem_word(mem_addr);
                gap     = pick_gap(ack_mode);
            end else begin
                mem_ack = 1'b0;
                mem_rd  = $urandom;
                gap     = gap - 1;
                wait_sum = wait_sum + 1;
            end
        end else begin
            mem_ack = 1'b0;
            mem_rd  = $urandom;
            gap     = pick_gap(ack_mode);
        end
    end

    initial begin
        // Stale contents before the first flush: everything looks valid.
        for (int i = 0; i < SETS; i++) begin
            cache_valid[i] = 1'b1;
            cache_tag[i]   = '0;
        end
        for (int i = 0; i < SETS*WORDS; i++) cache_data[i] = '0;
        forever begin
            @(posedge clk);
            #3;
            if (d_we) begin
                cache_data[d_addr[SET_W+LINE_W+1:2]] = d_wd;
                if (d_cnt < LOGN) d_log_addr[d_cnt] = d_addr;
                d_cnt = d_cnt + 1;
            end
            if (v_we) begin
                cache_valid[v_set] = v_val;
                cache_tag[v_set]   = v_tag;
                if (v_val) v1_cnt = v1_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Starts at the first FLUSH cycle, ends in the first IDLE cycle.
    task automatic run_flush(input string tag);
        for (int i = 0; i < SETS; i++) begin
            settle();
            chk(tag, {stall, v_we, v_val, mem_req, d_we, v_set},
                {5'b11000, SET_W'(i)});
            next();
        end
    endtask

    logic              ref_valid [SETS];
    logic [TAG_W-1:0]  ref_tag   [SETS];

    initial begin
        logic [31:0] a;
        int s, t, stalled, exp_stall, ws0, dc0, v0, nvalid;
        logic exp_hit;

        // ---- reset and initial flush ----
        next();
        settle();
        chk("rst_stall", stall, 1);
        chk("rst_quiet", {mem_req, d_we, v_we}, 0);
        next();
        reset = 1'b0;
        run_flush("init_flush");
        settle();
        chk("idle_no_req", stall, 0);
        nvalid = 0;
        for (int i = 0; i < SETS; i++) nvalid += int'(cache_valid[i]);
        chk("all_invalid", nvalid, 0);

        // ---- miss, zero-wait memory ----
        ack_mode = 0;
        next();
        pc_req = 1'b1; pc_addr = 32'h0000_0108;
        settle();
        chk("miss_stall", {stall, mem_req}, 2'b10);
        for (int k = 0; k < 4; k++) begin
            next();
            settle();
            chk("fill_addr", mem_addr, 32'h100 + 4*k);
            chk("fill_dwe", {d_we, d_addr}, {1'b1, 32'h100 + 32'(4*k)});
            chk("fill_dwd", d_wd, mem_word(32'h100 + 32'(4*k)));
            chk("fill_vwe", {stall, v_we}, {1'b1, k == 3});
            if (k == 3)
                chk("fill_vwr", {v_set, v_tag, v_val}, {12'h010, 16'h0000, 1'b1});
        end
        next(); settle();
        chk("done", {stall, mem_req, d_we}, 3'b100);
        next(); settle();
        chk("release", stall, 0);

        // ---- hit at 0x1234_5678 (line filled first) ----
        next();
        pc_addr = 32'h1234_5678;
        settle();
        stalled = 0;
        while (stall && stalled < 50) begin stalled++; next(); settle(); end
        chk("hit_prep_release", stall, 0);
        next(); pc_req = 1'b0; settle();
        next(); pc_req = 1'b1; settle();
        chk("hit_stall", stall, 0);
        chk("hit_ctag", {c_valid, c_tag}, {1'b1, 16'h1234});
        chk("hit_memreq", mem_req, 0);
        next(); settle();
        chk("hit_memreq2", {stall, mem_req}, 0);

        // ---- wait states: ack every 3rd cycle, pc change mid-fill ----
        ack_mode = 1;
        dc0 = d_cnt; v0 = v1_cnt;
        next();
        pc_addr = 32'h0000_3000;
        settle();
        chk("ws_miss", stall, 1);
        for (int k = 0; k < 12; k++) begin
            next();
            if (k == 1) pc_addr = 32'h0000_2000;
            settle();
            chk("ws_addr", {mem_req, mem_addr}, {1'b1, 32'h3000 + 32'(4*(k/3))});
            chk("ws_dwe", d_we, (k % 3) == 2);
            chk("ws_vwe", v_we, k == 11);
        end
        next(); pc_addr = 32'h0000_3000; settle();
        chk("ws_done", {stall, mem_req, d_we}, 3'b100);
        next(); settle();
        chk("ws_hit", stall, 0);
        chk("ws_dwe_count", d_cnt - dc0, 4);
        chk("ws_valid_count", v1_cnt - v0, 1);

        // ---- flush during fill ----
        ack_mode = 0;
        next();
        pc_addr = 32'h0000_4000;
        settle();
        for (int k = 0; k < 4; k++) begin
            next();
            flush = (k == 1);
            settle();
            chk("fl_fill", {d_we, v_we, v_val}, {1'b1, k == 3, k == 3});
        end
        next(); flush = 1'b0; settle();
        chk("fl_done", {stall, mem_req, v_we}, 3'b100);
        next(); settle();
        chk("fl_pend_idle", {stall, mem_req, v_we}, 3'b100);
        next();
        run_flush("flush_after_fill");
        pc_req = 1'b0;
        settle();
        chk("fl_idle", stall, 0);

        // ---- reset mid-fill ----
        v0 = v1_cnt;
        next();
        pc_req = 1'b1; pc_addr = 32'h0000_5000;
        settle();
        next(); settle();
        chk("rm_ack1", d_we, 1);
        next(); settle();
        chk("rm_ack2", d_we, 1);
        next(); reset = 1'b1; settle();
        chk("rm_rst", {stall, mem_req, d_we, v_we}, 4'b1000);
        next(); reset = 1'b0; pc_req = 1'b0;
        run_flush("flush_after_reset");
        settle();
        chk("rm_idle", stall, 0);
        chk("rm_no_valid_write", v1_cnt - v0, 0);
        chk("rm_set_invalid", cache_valid[12'h500], 0);

        // ---- randomized fetches against the line-level model ----
        for (int i = 0; i < SETS; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end
        ack_mode = 2;
        for (int n = 0; n < 80; n++) begin
            s = int'($urandom_range(0, 7));
            t = int'($urandom_range(0, 2));
            a = {TAG_W'(t), SET_W'(s), LINE_W'($urandom_range(0, WORDS-1)), 2'b00};
            exp_hit = ref_valid[s] && (ref_tag[s] == TAG_W'(t));
            ws0 = wait_sum; dc0 = d_cnt;
            next();
            pc_req = 1'b1; pc_addr = a;
            settle();
            stalled = 0;
            while (stall && stalled < 100) begin stalled++; next(); settle(); end
            chk("rnd_release", stall, 0);
            exp_stall = exp_hit ? 0 : WORDS + 2 + (wait_sum - ws0);
            chk("rnd_stall_cycles", stalled, exp_stall);
            chk("rnd_data", cache_data[a[SET_W+LINE_W+1:2]], mem_word(a));
            if (exp_hit) begin
                chk("rnd_hit_no_fill", d_cnt - dc0, 0);
            end else begin
                chk("rnd_fill_words", d_cnt - dc0, WORDS);
                for (int w = 0; w < WORDS; w++)
                    chk("rnd_fill_addr", d_log_addr[(dc0 + w) % LOGN],
                        {a[31:LINE_W+2], LINE_W'(w), 2'b00});
            end
            ref_valid[s] = 1'b1;
            ref_tag[s]   = TAG_W'(t);
            if ($urandom_range(0, 3) == 0) begin
                next(); pc_req = 1'b0; settle();
                chk("rnd_idle", {stall, mem_req}, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
